counter_193_driver: RTL and testbench
=====================================

Name: counter_193_driver

Overview:
Synchronous sequencer that drives the control pins of a 74x193 up/down counter stage: clr, npl, p, cpu, cpd. It also consumes the stage's ntcu/ntcd terminal-count outputs. Commands arrive over a valid/ready handshake and are expanded into correctly timed clear strobes, load strobes and count pulses. A shadow copy of the counter value is kept so that carry and borrow behaviour can be cross-checked. The block sits between microcode control logic and discrete counter stages, for example in register increment/decrement paths.

Parameters:
T_LO, 3, cycles each strobe/pulse is held active; minimum 3.
T_HI, 2, cycles of inactive recovery after each strobe/pulse; minimum 1.
N_W, 8, width of the pulse-count field.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous reset, active-high.
cmd_valid  in  1  a command is presented.
cmd_ready  out  1  the block can accept a command.
cmd_op  in  2  operation: 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN.
cmd_data  in  4  load value (LOAD only).
cmd_n  in  N_W  number of count pulses (UP/DOWN only).
clr  out  1  counter async clear, active-high.
npl  out  1  counter parallel load, active-low.
p  out  4  counter parallel data.
cpu  out  1  count-up clock; counts on the rising edge.
cpd  out  1  count-down clock; counts on the rising edge.
ntcu  in  1  counter carry output, asynchronous.
ntcd  in  1  counter borrow output, asynchronous.
busy  out  1  a command is in progress.
shadow_q  out  4  expected counter value.
carry_seen  out  1  sticky: a synchronised ntcu=0 was sampled during the current command.
borrow_seen  out  1  sticky: a synchronised ntcd=0 was sampled during the current command.
tc_err  out  1  sticky: a terminal-count output disagreed with shadow_q.

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - clr=0, npl=1, cpu=1, cpd=1, p=0
  - shadow_q=0, busy=0, cmd_ready=0
  - carry_seen=0, borrow_seen=0, tc_err=0
  - FSM to IDLE; synchroniser flops to 1.
- Reset mid-command aborts the command. Outputs return to the reset values on that same edge, so a partial pulse is cut short with a rising edge.
- cmd_ready=1 only in IDLE when reset is low. A command is accepted when cmd_valid & cmd_ready. On accept:
  - op, data and n are latched; busy=1 from the next cycle.
  - carry_seen and borrow_seen clear.
  - tc_err is sticky until reset.
- FSM states: IDLE, STROBE, RECOVER, PULSE_LO, PULSE_HI.
  - CLEAR: STROBE holds clr=1 for T_LO cycles, then RECOVER holds clr=0 for T_HI cycles, then IDLE. shadow_q=0 when the strobe ends.
  - LOAD: p=cmd_data from the accept edge, held until the next LOAD. STROBE holds npl=0 for T_LO cycles, then RECOVER for T_HI cycles, then IDLE. shadow_q=data when the strobe ends.
  - UP: n iterations of PULSE_LO (cpu=0 for T_LO cycles) then PULSE_HI (cpu=1 for T_HI cycles). cpd stays 1 throughout. shadow_q increments mod 16 on each cpu 0->1 edge, so 15 wraps to 0.
  - DOWN: same as UP using cpd, with cpu held at 1. shadow_q decrements mod 16, so 0 wraps to 15.
  - UP/DOWN with n=0: IDLE again on the cycle after accept. No pin activity.
  - A command is never accepted while busy; there is no overlap.
- ntcu and ntcd each pass through a 2-flop synchroniser. Check timing:
  - The synchronised value is evaluated on the last PULSE_LO cycle, before the release edge.
  - UP: expected ntcu = 0 iff shadow_q==15. Sync ntcu=0 sets carry_seen. Any mismatch sets tc_err.
  - DOWN: same rule with ntcd against shadow_q==0, setting borrow_seen.
  - No checks are made in other states.
- Only one of clr, npl and the counting clocks is ever active at a time.
- busy=1 in every state except IDLE. busy falls on the same edge that cmd_ready rises.

Decomposition:
- Shared package counter_193_pkg holds:
  - op encodings OP_CLEAR/OP_LOAD/OP_UP/OP_DOWN;
  - FSM state encodings;
  - minimum-timing constants T_LO_MIN=3 and T_HI_MIN=1.
- One sub-module, sync2: a 2-flop synchroniser with its reset value as a parameter. It is instantiated for ntcu and ntcd.
- The bench pairs the driver with the existing counter_193 model.

Test Plan:
- Reset, then LOAD data=4'b1101 -> npl low for exactly 3 cycles with p=1101; shadow_q=13; cmd_ready returns after 2 recovery cycles.
- LOAD 14, then UP n=3 -> three cpu pulses; counter q sequence 15,0,1; shadow_q=1; carry_seen=1; tc_err=0; cpd constant 1.
- LOAD 1, then DOWN n=2 -> q 0 then 15; borrow_seen=1 on the pulse where q=0; shadow_q=15; tc_err=0.
- CLEAR after LOAD 9 -> clr high 3 cycles; q=0; shadow_q=0. Then UP n=0 -> no pin toggles, busy high for 1 cycle.
- Force the ntcu model input stuck at 0 during UP n=1 from q=5 -> tc_err=1 and stays set across later commands until reset.
- Assert reset during the 2nd PULSE_LO of UP n=4 -> next edge gives cpu=1, busy=0, shadow_q=0; cmd_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/counter_193_pkg.sv
// Shared encodings and timing floors for the 74x193 control sequencer.
package counter_193_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STROBE   = 3'd1,
        RECOVER  = 3'd2,
        PULSE_LO = 3'd3,
        PULSE_HI = 3'd4
    } state_e;

    localparam int T_LO_MIN = 3;
    localparam int T_HI_MIN = 1;

endpackage

// File: rtl/counter_193_driver_sync2.sv
// Two-flop synchroniser for the counter's asynchronous terminal-count outputs.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/counter_193_driver.sv
// Expands CLEAR/LOAD/UP/DOWN commands into timed 74x193 pin activity and
// cross-checks the counter's carry/borrow outputs against a shadow value.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// STROBE   | clr high or npl low for T_LO cycles
// RECOVER  | inactive recovery after a strobe (also the single cycle of n=0)
// PULSE_LO | cpu or cpd low for T_LO cycles; terminal count checked on last cycle
// PULSE_HI | count clock high for T_HI cycles
module counter_193_driver
    import counter_193_pkg::*;
#(
    parameter int T_LO = 3,
    parameter int T_HI = 2,
    parameter int N_W  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [3:0]     cmd_data,
    input  logic [N_W-1:0] cmd_n,
    output logic           clr,
    output logic           npl,
    output logic [3:0]     p,
    output logic           cpu,
    output logic           cpd,
    input  logic           ntcu,
    input  logic           ntcd,
    output logic           busy,
    output logic [3:0]     shadow_q,
    output logic           carry_seen,
    output logic           borrow_seen,
    output logic           tc_err
);

    // Timings below the floors are raised so the synchroniser always settles
    // before the terminal-count check on the last low cycle.
    localparam int LO = (T_LO < T_LO_MIN) ? T_LO_MIN : T_LO;
    localparam int HI = (T_HI < T_HI_MIN) ? T_HI_MIN : T_HI;
    localparam int TW = $clog2(((LO > HI) ? LO : HI) + 1);
    localparam logic [TW-1:0] LO_LOAD = TW'(LO - 1);
    localparam logic [TW-1:0] HI_LOAD = TW'(HI - 1);

    state_e         state, state_n;
    op_e            op, op_n;
    logic [N_W-1:0] n_left, n_left_n;
    logic [TW-1:0]  timer, timer_n;
    logic           ready_r, accept, ntcu_s, ntcd_s, lo_end, strobe_end;
    logic           clr_n, npl_n, cpu_n, cpd_n;

    sync2 #(.RST_VAL(1'b1)) u_sync_ntcu (.clk(clk), .reset(reset), .d(ntcu), .q(ntcu_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_ntcd (.clk(clk), .reset(reset), .d(ntcd), .q(ntcd_s));

    assign cmd_ready  = ready_r & ~reset;
    assign accept     = cmd_valid & cmd_ready;
    assign busy       = (state != IDLE);
    assign lo_end     = (state == PULSE_LO) && (timer == '0);
    assign strobe_end = (state == STROBE) && (timer == '0);

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        n_left_n = n_left;
        op_n     = op;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    op_n    = op_e'(cmd_op);
                    timer_n = LO_LOAD;
                    if (op_n == OP_CLEAR || op_n == OP_LOAD) begin
                        state_n = STROBE;
                    end else if (cmd_n == '0) begin
                        state_n = RECOVER;
                        timer_n = '0;
                    end else begin
                        state_n  = PULSE_LO;
                        n_left_n = cmd_n;
                    end
                end
            end
            STROBE: begin
                if (timer == '0) begin
                    state_n = RECOVER;
                    timer_n = HI_LOAD;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            RECOVER: begin
                if (timer == '0) state_n = IDLE;
                else             timer_n = timer - 1'b1;
            end
            PULSE_LO: begin
                if (timer == '0) begin
                    state_n  = PULSE_HI;
                    timer_n  = HI_LOAD;
                    n_left_n = n_left - 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            PULSE_HI: begin
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else if (n_left == '0) begin
                    state_n = IDLE;
                end else begin
                    state_n = PULSE_LO;
                    timer_n = LO_LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
        clr_n = (state_n == STROBE) && (op_n == OP_CLEAR);
        npl_n = !((state_n == STROBE) && (op_n == OP_LOAD));
        cpu_n = !((state_n == PULSE_LO) && (op_n == OP_UP));
        cpd_n = !((state_n == PULSE_LO) && (op_n == OP_DOWN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op          <= OP_CLEAR;
            n_left      <= '0;
            timer       <= '0;
            ready_r     <= 1'b0;
            clr         <= 1'b0;
            npl         <= 1'b1;
            cpu         <= 1'b1;
            cpd         <= 1'b1;
            p           <= 4'd0;
            shadow_q    <= 4'd0;
            carry_seen  <= 1'b0;
            borrow_seen <= 1'b0;
            tc_err      <= 1'b0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            n_left  <= n_left_n;
            timer   <= timer_n;
            ready_r <= (state_n == IDLE);
            clr     <= clr_n;
            npl     <= npl_n;
            cpu     <= cpu_n;
            cpd     <= cpd_n;
            if (accept && op_n == OP_LOAD) p <= cmd_data;
            if (accept) begin
                carry_seen  <= 1'b0;
                borrow_seen <= 1'b0;
            end
            if (strobe_end) shadow_q <= (op == OP_LOAD) ? p : 4'd0;
            // Shadow still holds the pre-release value here, so it is the
            // value the counter shows while its clock is low.
            if (lo_end) begin
                if (op == OP_UP) begin
                    shadow_q <= shadow_q + 4'd1;
                    if (!ntcu_s) carry_seen <= 1'b1;
                    if (ntcu_s == (shadow_q == 4'd15)) tc_err <= 1'b1;
                end else begin
                    shadow_q <= shadow_q - 4'd1;
                    if (!ntcd_s) borrow_seen <= 1'b1;
                    if (ntcd_s == (shadow_q == 4'd0)) tc_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_193_driver.sv
// Scoreboard bench: driver paired with a behavioural 74x193 counter model.
module tb_counter_193_driver;

    localparam int T_LO = 3;
    localparam int T_HI = 2;
    localparam int N_W  = 8;
    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_LOAD  = 2'b01;
    localparam logic [1:0] C_UP    = 2'b10;
    localparam logic [1:0] C_DOWN  = 2'b11;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'b00;
    logic [3:0]     cmd_data = 4'd0;
    logic [N_W-1:0] cmd_n = '0;
    logic           clr, npl, cpu, cpd, ntcu, ntcd, busy;
    logic [3:0]     p, shadow_q;
    logic           carry_seen, borrow_seen, tc_err;

    counter_193_driver #(.T_LO(T_LO), .T_HI(T_HI), .N_W(N_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_n(cmd_n),
        .clr(clr), .npl(npl), .p(p), .cpu(cpu), .cpd(cpd),
        .ntcu(ntcu), .ntcd(ntcd), .busy(busy), .shadow_q(shadow_q),
        .carry_seen(carry_seen), .borrow_seen(borrow_seen), .tc_err(tc_err)
    );

    always #5 clk = ~clk;

    // 74x193 behaviour: async clear, async active-low load, count on rising clock edges.
    logic [3:0] cnt_q = 4'd0;
    logic       cpu_prev = 1'b1;
    logic       cpd_prev = 1'b1;
    logic       ntcu_stuck = 1'b0;

    always @(cpu or cpd or clr or npl or p) begin
        if (clr)                                cnt_q = 4'd0;
        else if (!npl)                          cnt_q = p;
        else if (cpu && !cpu_prev && cpd)       cnt_q = cnt_q + 4'd1;
        else if (cpd && !cpd_prev && cpu)       cnt_q = cnt_q - 4'd1;
        cpu_prev = cpu;
        cpd_prev = cpd;
    end

    always_comb begin
        ntcu = ntcu_stuck ? 1'b0 : !((cnt_q == 4'd15) && !cpu);
        ntcd = !((cnt_q == 4'd0) && !cpd);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    typedef struct {
        logic [3:0] shadow;
        logic       carry;
        logic       borrow;
        logic       tc;
        logic [3:0] p;
        int         busy_cyc;
        int         clr_cyc;
        int         npl_cyc;
        int         cpu_cyc;
        int         cpd_cyc;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] mdl_shadow = 4'd0;
    logic [3:0] mdl_p = 4'd0;
    logic       mdl_tc = 1'b0;

    // Monitor: accumulate pin activity while busy, compare when busy falls.
    logic busy_prev = 1'b0;
    int   acc_busy, acc_clr, acc_npl, acc_cpu, acc_cpd;
    logic excl_bad, p_bad;

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            busy_prev = 1'b0;
            acc_busy = 0; acc_clr = 0; acc_npl = 0; acc_cpu = 0; acc_cpd = 0;
            excl_bad = 1'b0; p_bad = 1'b0;
        end else begin
            if (busy) begin
                acc_busy++;
                if (clr)  acc_clr++;
                if (!npl) acc_npl++;
                if (!cpu) acc_cpu++;
                if (!cpd) acc_cpd++;
                if (int'(clr) + int'(!npl) + int'(!cpu) + int'(!cpd) > 1) excl_bad = 1'b1;
                if (!npl && sb_q.size() > 0 && p != sb_q[0].p) p_bad = 1'b1;
            end
            if (busy_prev && !busy) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("shadow_q",       int'(shadow_q),    int'(e.shadow));
                    check("counter_q",      int'(cnt_q),       int'(e.shadow));
                    check("carry_seen",     int'(carry_seen),  int'(e.carry));
                    check("borrow_seen",    int'(borrow_seen), int'(e.borrow));
                    check("tc_err",         int'(tc_err),      int'(e.tc));
                    check("p_hold",         int'(p),           int'(e.p));
                    check("busy_cycles",    acc_busy,          e.busy_cyc);
                    check("clr_cycles",     acc_clr,           e.clr_cyc);
                    check("npl_low_cycles", acc_npl,           e.npl_cyc);
                    check("cpu_low_cycles", acc_cpu,           e.cpu_cyc);
                    check("cpd_low_cycles", acc_cpd,           e.cpd_cyc);
                    check("ready_at_done",  int'(cmd_ready),   1);
                    check("pins_exclusive", int'(excl_bad),    0);
                    check("p_during_load",  int'(p_bad),       0);
                end
                acc_busy = 0; acc_clr = 0; acc_npl = 0; acc_cpu = 0; acc_cpd = 0;
                excl_bad = 1'b0; p_bad = 1'b0;
            end
            busy_prev = busy;
        end
    end

    task automatic wait_ready();
        int budget = 0;
        while (!cmd_ready && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] data, input int n);
        exp_t       e;
        logic [3:0] v;
        wait_ready();
        if (!cmd_ready) return;
        e.shadow = mdl_shadow; e.carry = 1'b0; e.borrow = 1'b0; e.tc = mdl_tc;
        e.p = mdl_p; e.busy_cyc = T_LO + T_HI;
        e.clr_cyc = 0; e.npl_cyc = 0; e.cpu_cyc = 0; e.cpd_cyc = 0;
        case (op)
            C_CLEAR: begin e.shadow = 4'd0; e.clr_cyc = T_LO; end
            C_LOAD:  begin e.shadow = data; e.npl_cyc = T_LO; e.p = data; end
            C_UP: begin
                for (int k = 0; k < n; k++) begin
                    v = mdl_shadow + 4'(k);
                    if (ntcu_stuck) begin
                        e.carry = 1'b1;
                        if (v != 4'd15) e.tc = 1'b1;
                    end else if (v == 4'd15) begin
                        e.carry = 1'b1;
                    end
                end
                e.shadow   = mdl_shadow + 4'(n);
                e.cpu_cyc  = n * T_LO;
                e.busy_cyc = (n == 0) ? 1 : n * (T_LO + T_HI);
            end
            default: begin
                for (int k = 0; k < n; k++) begin
                    v = mdl_shadow - 4'(k);
                    if (v == 4'd0) e.borrow = 1'b1;
                end
                e.shadow   = mdl_shadow - 4'(n);
                e.cpd_cyc  = n * T_LO;
                e.busy_cyc = (n == 0) ? 1 : n * (T_LO + T_HI);
            end
        endcase
        mdl_shadow = e.shadow;
        mdl_p      = e.p;
        mdl_tc     = e.tc;
        cmd_op    = op;
        cmd_data  = data;
        cmd_n     = N_W'(n);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back(e);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int   falls;
        logic prev;

        repeat (3) @(posedge clk);
        #1;
        check("rst_clr",      int'(clr),         0);
        check("rst_npl",      int'(npl),         1);
        check("rst_cpu",      int'(cpu),         1);
        check("rst_cpd",      int'(cpd),         1);
        check("rst_p",        int'(p),           0);
        check("rst_shadow",   int'(shadow_q),    0);
        check("rst_busy",     int'(busy),        0);
        check("rst_ready",    int'(cmd_ready),   0);
        check("rst_flags",    int'({carry_seen, borrow_seen, tc_err}), 0);
        reset = 1'b0;
        check("ready_after_release", int'(cmd_ready), 0);
        @(posedge clk); #1;
        check("ready_one_cycle_later", int'(cmd_ready), 1);

        issue(C_LOAD, 4'b1101, 0);
        issue(C_LOAD, 4'd14, 0);
        issue(C_UP, 4'd0, 3);
        issue(C_LOAD, 4'd1, 0);
        issue(C_DOWN, 4'd0, 2);
        issue(C_LOAD, 4'd9, 0);
        issue(C_CLEAR, 4'd0, 0);
        issue(C_UP, 4'd0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            int         n;
            op = 2'($urandom_range(3, 0));
            n  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(20, 13)) : int'($urandom_range(6, 0));
            issue(op, 4'($urandom), n);
        end

        issue(C_LOAD, 4'd5, 0);
        ntcu_stuck = 1'b1;
        issue(C_UP, 4'd0, 1);
        wait_ready();
        ntcu_stuck = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue(2'($urandom_range(3, 0)), 4'($urandom), int'($urandom_range(5, 0)));
        end

        issue(C_UP, 4'd0, 4);
        falls = 0;
        prev  = 1'b1;
        for (int i = 0; i < 200 && falls < 2; i++) begin
            @(negedge clk);
            if (prev && !cpu) falls++;
            prev = cpu;
        end
        check("second_pulse_seen", falls, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_cpu",    int'(cpu),       1);
        check("abort_busy",   int'(busy),      0);
        check("abort_shadow", int'(shadow_q),  0);
        check("abort_ready",  int'(cmd_ready), 0);
        check("abort_tc_err", int'(tc_err),    0);
        @(negedge clk); #1;
        reset = 1'b0;
        check("abort_ready_on_release", int'(cmd_ready), 0);
        @(posedge clk); #1;
        check("abort_ready_next_cycle", int'(cmd_ready), 1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
